sfx_voice_mixer: RTL and testbench

Parametrised multi-voice square-wave sound-effect generator for the game audio path. Each voice is started by a one-cycle trigger that latches a pitch (half-period in CLOCK_50 cycles) and a duration (in audio sample ticks), then plays a ±AMP square wave until the duration expires. Active voices are summed with signed saturation into one 32-bit sample. The sample feeds the audio controller's left/right output channels, advanced by the controller's write strobe.

---
 rtl/sfx_voice_mixer.sv | 118 +++++++++++
 tb/tb_sfx_voice_mixer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_voice_mixer.sv
// ============================================================================
// Module   : sfx_voice_mixer
// Summary  : Multi-voice square-wave sound-effect generator with saturating mix
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_voice_mixer #(
  parameter int                 N_VOICES = 4,
  parameter int                 CNT_W    = 19,
  parameter int                 DUR_W    = 16,
  parameter logic signed [31:0] AMP      = 32'sd10000000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [N_VOICES-1:0]         trig,
  input  logic [N_VOICES*CNT_W-1:0]   half_period,
  input  logic [N_VOICES*DUR_W-1:0]   duration,
  input  logic                        mute,
  input  logic                        sample_tick,
  output logic signed [31:0]          sample_out,
  output logic [N_VOICES-1:0]         active,
  output logic                        busy
);

  localparam int SUM_W = 32 + $clog2(N_VOICES);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(64'sd2147483647);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-64'sd2147483648);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } voice_state_t;

  logic signed [31:0] contrib [N_VOICES];

  for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
    voice_state_t     state_q;
    voice_state_t     state_d;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] cnt;
    logic [DUR_W-1:0] rem;
    logic             phase;
    logic             load;
    logic [CNT_W-1:0] hp_in;
    logic [DUR_W-1:0] dur_in;

    assign hp_in  = half_period[i*CNT_W +: CNT_W];
    assign dur_in = duration[i*DUR_W +: DUR_W];

    // A zero-duration trigger is treated as no trigger at all.
    always_comb begin
      load    = trig[i] && (dur_in != '0);
      state_d = state_q;
      case (state_q)
        IDLE: if (load) state_d = PLAY;
        PLAY: begin
          if (load)                               state_d = PLAY;
          else if (sample_tick && rem == DUR_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state_q <= IDLE;
        hp      <= '0;
        cnt     <= '0;
        rem     <= '0;
        phase   <= 1'b0;
      end else begin
        state_q <= state_d;
        if (load) begin
          hp    <= hp_in;
          rem   <= dur_in;
          cnt   <= '0;
          phase <= 1'b0;
        end else if (state_q == PLAY) begin
          if (cnt == hp) begin
            cnt   <= '0;
            phase <= ~phase;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (sample_tick) rem <= rem - DUR_W'(1);
        end
      end
    end

    assign active[i]  = (state_q == PLAY);
    assign contrib[i] = (state_q != PLAY) ? 32'sd0 : (phase ? -AMP : AMP);
  end : g_voice

  logic signed [SUM_W-1:0] sum;
  logic signed [31:0]      mix;

  always_comb begin
    sum = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      sum = sum + SUM_W'(contrib[v]);
    end
    if (mute)             mix = 32'sd0;
    else if (sum > SAT_HI) mix = 32'sh7FFF_FFFF;
    else if (sum < SAT_LO) mix = 32'sh8000_0000;
    else                  mix = sum[31:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)            sample_out <= 32'sd0;
    else if (sample_tick) sample_out <= mix;
  end

  assign busy = |active;

endmodule

`default_nettype wire

// File: tb/tb_sfx_voice_mixer.sv
// ============================================================================
// Module   : tb_sfx_voice_mixer
// Summary  : Directed bench for sfx_voice_mixer (default AMP and AMP = 2^30)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfx_voice_mixer;

  localparam int N     = 4;
  localparam int CW    = 19;
  localparam int DW    = 16;
  localparam int A     = 10000000;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      trig;
  logic [N*CW-1:0]   half_period;
  logic [N*DW-1:0]   duration;
  logic              mute;
  logic              sample_tick;
  logic signed [31:0] sample_out;
  logic [N-1:0]      active;
  logic              busy;
  logic signed [31:0] sample_sat;
  logic [N-1:0]      active_sat;
  logic              busy_sat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sfx_voice_mixer #(.N_VOICES(N), .CNT_W(CW), .DUR_W(DW), .AMP(32'sd10000000)) dut (
    .CLOCK_50(clk), .reset(reset), .trig(trig), .half_period(half_period),
    .duration(duration), .mute(mute), .sample_tick(sample_tick),
    .sample_out(sample_out), .active(active), .busy(busy)
  );

  sfx_voice_mixer #(.N_VOICES(N), .CNT_W(CW), .DUR_W(DW), .AMP(32'sd1073741824)) dut_sat (
    .CLOCK_50(clk), .reset(reset), .trig(trig), .half_period(half_period),
    .duration(duration), .mute(mute), .sample_tick(sample_tick),
    .sample_out(sample_sat), .active(active_sat), .busy(busy_sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_voice(input int i, input int hp, input int dur);
    half_period[i*CW +: CW] = CW'(hp);
    duration[i*DW +: DW]    = DW'(dur);
  endtask

  // Pulse trig for one cycle; returns at the falling edge after the load edge.
  task automatic fire(input logic [N-1:0] mask);
    trig = mask;
    @(negedge clk);
    trig = '0;
  endtask

  // One-cycle sample_tick, then results are visible at the returning negedge.
  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
  endtask

  int exp1 [5]  = '{A, A, -A, -A, A};
  int exp2a [4] = '{2*A, 2*A, -2*A, -2*A};
  int exp2b [4] = '{2*A, 0, 0, -2*A};
  int exp4 [4]  = '{A, A, -A, -A};

  initial begin
    reset = 1'b1; trig = '0; half_period = '0; duration = '0;
    mute = 1'b0; sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample", sample_out, 0);
    chk("rst_active", active, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    gap();

    // Single voice: hp=3 toggles every 4 cycles, ticks every 2 cycles.
    set_voice(0, 3, 5);
    fire(4'b0001);
    chk("t1_active_start", active, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      do_tick();
      chk($sformatf("t1_sample%0d", k), sample_out, exp1[k]);
      chk($sformatf("t1_active%0d", k), active[0], (k < 4) ? 1 : 0);
      gap();
    end
    do_tick();
    chk("t1_after", sample_out, 0);
    chk("t1_busy", busy, 0);
    gap();

    // Two voices in phase.
    set_voice(0, 3, 4); set_voice(1, 3, 4);
    fire(4'b0011);
    for (int k = 0; k < 4; k++) begin
      do_tick();
      chk($sformatf("t2a_sample%0d", k), sample_out, exp2a[k]);
      gap();
    end
    chk("t2a_idle", active, 0);

    // Voice 1 at hp=1 drifts against voice 0, giving cancelling mixes.
    set_voice(0, 3, 4); set_voice(1, 1, 4);
    fire(4'b0011);
    for (int k = 0; k < 4; k++) begin
      do_tick();
      chk($sformatf("t2b_sample%0d", k), sample_out, exp2b[k]);
      gap();
    end
    chk("t2b_idle", active, 0);

    // Four voices together: plain sum on dut, saturation on dut_sat.
    for (int v = 0; v < N; v++) set_voice(v, 3, 3);
    fire(4'b1111);
    chk("t3_all_active", active_sat, 4'b1111);
    do_tick();
    chk("t3_sum_pos", sample_out, 4*A);
    chk("t3_sat_pos", sample_sat, 64'sd2147483647);
    gap();
    do_tick();
    chk("t3_sat_pos2", sample_sat, 64'sd2147483647);
    gap();
    do_tick();
    chk("t3_sum_neg", sample_out, -4*A);
    chk("t3_sat_neg", sample_sat, -64'sd2147483648);
    chk("t3_sat_idle", busy_sat, 0);
    gap();

    // Retrigger voice 2 after three ticks of a ten-tick tone.
    set_voice(2, 3, 10);
    fire(4'b0100);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      gap();
    end
    chk("t4_still_active", active[2], 1);
    set_voice(2, 3, 4);
    fire(4'b0100);
    for (int k = 0; k < 4; k++) begin
      do_tick();
      chk($sformatf("t4_sample%0d", k), sample_out, exp4[k]);
      chk($sformatf("t4_active%0d", k), active[2], (k < 3) ? 1 : 0);
      gap();
    end
    do_tick();
    chk("t4_after", sample_out, 0);

    // Zero duration is ignored.
    set_voice(3, 3, 0);
    fire(4'b1000);
    chk("t5_zero_dur", active, 0);
    gap();
    chk("t5_zero_dur_busy", busy, 0);

    // Trigger and tick in the same cycle: reload wins, no decrement.
    set_voice(0, 3, 2);
    fire(4'b0001);
    do_tick();
    chk("t6_first", sample_out, A);
    set_voice(0, 3, 3);
    trig = 4'b0001; sample_tick = 1'b1;
    @(negedge clk);
    trig = '0; sample_tick = 1'b0;
    chk("t6_coincident_sample", sample_out, A);
    chk("t6_coincident_active", active[0], 1);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      chk($sformatf("t6_sample%0d", k), sample_out, exp4[k]);
      chk($sformatf("t6_active%0d", k), active[0], (k < 2) ? 1 : 0);
      gap();
    end

    // Mute zeroes the mix but the voice keeps playing.
    mute = 1'b1;
    set_voice(1, 3, 3);
    fire(4'b0010);
    do_tick();
    chk("t7_muted", sample_out, 0);
    chk("t7_muted_active", active[1], 1);
    gap();
    mute = 1'b0;
    do_tick();
    chk("t7_unmuted_pos", sample_out, A);
    gap();
    do_tick();
    chk("t7_unmuted_neg", sample_out, -A);
    chk("t7_done", active, 0);
    gap();

    // Reset mid-play; a trigger during reset is dropped.
    set_voice(0, 3, 10);
    fire(4'b0001);
    do_tick();
    chk("t8_playing", sample_out, A);
    set_voice(1, 3, 5);
    reset = 1'b1; trig = 4'b0010;
    @(negedge clk);
    reset = 1'b0; trig = '0;
    chk("t8_rst_active", active, 0);
    chk("t8_rst_sample", sample_out, 0);
    chk("t8_rst_busy", busy, 0);
    gap();
    chk("t8_trig_dropped", active, 0);
    do_tick();
    chk("t8_after_tick", sample_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
